// File: rtl/mem_unit_sb.sv
// MEM-stage load/store unit with an in-order store buffer draining to a
// word-addressed data memory; loads forward from the youngest matching entry.
module mem_unit_sb #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 8,
  parameter int SB_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        isld,
  input  logic                        isst,
  input  logic [DATA_W-1:0]           op2,
  input  logic [DATA_W-1:0]           aluresult,
  input  logic                        sb_hold,
  output logic                        st_ready,
  output logic                        ld_valid,
  output logic [DATA_W-1:0]           ldresult,
  output logic [$clog2(SB_DEPTH):0]   sb_count
);

  localparam int PTR_W     = $clog2(SB_DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam int MEM_DEPTH = 1 << ADDR_W;

  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] sb_addr [SB_DEPTH];
  logic [DATA_W-1:0] sb_data [SB_DEPTH];
  // Zero power-up image; rst never touches the array contents.
  logic [DATA_W-1:0] mem [MEM_DEPTH] = '{default: '0};

  logic [PTR_W-1:0]  head, tail;
  logic [CNT_W-1:0]  count;
  logic              st_acc, ld_acc, drain;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  assign addr     = aluresult[ADDR_W-1:0];
  assign st_ready = (count < CNT_W'(SB_DEPTH));
  assign sb_count = count;
  assign st_acc   = isst && st_ready;
  assign ld_acc   = isld && !isst;
  assign drain    = (count != '0) && !sb_hold;

  // Upper address bits alias by design.
  if (ADDR_W < DATA_W) begin : g_addr_alias
    logic unused_addr_hi;
    assign unused_addr_hi = ^aluresult[DATA_W-1:ADDR_W];
  end

  // Scan oldest to youngest so the last hit is the youngest; the head entry
  // being drained this cycle is still included, closing the read/write race.
  always_comb begin
    // NOTE: defaults first so no path through the loop leaves a latch.
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (CNT_W'(i) < count && sb_addr[head + PTR_W'(i)] == addr) begin
        fwd_hit  = 1'b1;
        fwd_data = sb_data[head + PTR_W'(i)];
      end
    end
  end

  // NOTE: buffer payload and memory carry no reset; only the pointers and
  // count are reset, which is enough to discard pending entries.
  always_ff @(posedge clk) begin
    if (st_acc) begin
      sb_addr[tail] <= addr;
      sb_data[tail] <= op2;
    end
    if (drain && !rst)
      mem[sb_addr[head]] <= sb_data[head];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      ld_valid <= 1'b0;
      ldresult <= '0;
    end else begin
      if (st_acc) tail <= tail + 1'b1;
      if (drain)  head <= head + 1'b1;
      case ({st_acc, drain})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      ld_valid <= ld_acc;
      if (ld_acc)
        ldresult <= fwd_hit ? fwd_data : mem[addr];
    end
  end

endmodule

// File: tb/tb_mem_unit_sb.sv
// Bench for mem_unit_sb: table of per-cycle vectors with hand-derived results,
// load expectations queued at issue and retired when ld_valid appears.
module tb_mem_unit_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic        isld, isst, sb_hold;
  logic [15:0] op2, aluresult;
  logic        st_ready, ld_valid;
  logic [15:0] ldresult;
  logic [2:0]  sb_count;

  mem_unit_sb #(.DATA_W(16), .ADDR_W(8), .SB_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .isld(isld), .isst(isst), .op2(op2),
    .aluresult(aluresult), .sb_hold(sb_hold), .st_ready(st_ready),
    .ld_valid(ld_valid), .ldresult(ldresult), .sb_count(sb_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        isld, isst, hold;
    logic [15:0] addr, data;
    logic        exp_rdy;
    int          exp_cnt;
    logic        exp_vld;
    logic [15:0] exp_ld;
  } vec_t;

  vec_t        tbl[$];
  logic [15:0] sb_q[$];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ld, st, hold, input logic [15:0] a, d,
                              input logic rdy, input int cnt, input logic vld,
                              input logic [15:0] res);
    vec_t t;
    t.isld = ld; t.isst = st; t.hold = hold; t.addr = a; t.data = d;
    t.exp_rdy = rdy; t.exp_cnt = cnt; t.exp_vld = vld; t.exp_ld = res;
    return t;
  endfunction

  // Inputs are driven 1 time unit after a rising edge; outputs are sampled
  // at the same offset after the next edge.
  task automatic run_vec(input vec_t t, input string tag);
    isld = t.isld; isst = t.isst; sb_hold = t.hold;
    aluresult = t.addr; op2 = t.data;
    if (t.isld && !t.isst) sb_q.push_back(t.exp_ld);
    check({tag, " st_ready"}, 32'(st_ready), 32'(t.exp_rdy));
    @(posedge clk); #1;
    check({tag, " sb_count"}, 32'(sb_count), 32'(t.exp_cnt));
    check({tag, " ld_valid"}, 32'(ld_valid), 32'(t.exp_vld));
    if (ld_valid) begin
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL %s unexpected load result: got 0x%0h expected none", tag, ldresult);
      end else begin
        check({tag, " ldresult"}, 32'(ldresult), 32'(sb_q.pop_front()));
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; isld = 0; isst = 0; sb_hold = 0; op2 = '0; aluresult = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset ld_valid", 32'(ld_valid), 0);
    check("reset ldresult", 32'(ldresult), 0);
    check("reset sb_count", 32'(sb_count), 0);
    check("reset st_ready", 32'(st_ready), 1);
    rst = 1'b0;

    //               ld st hd addr     data     rdy cnt vld result
    // round trip
    tbl.push_back(mk(0, 1, 0, 16'h0001, 16'hA5A5, 1, 1, 0, 16'h0000));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000));
    tbl.push_back(mk(1, 0, 0, 16'h0001, 16'h0000, 1, 0, 1, 16'hA5A5));
    // forwarding under hold
    tbl.push_back(mk(0, 1, 1, 16'h0003, 16'h100A, 1, 1, 0, 16'h0000));
    tbl.push_back(mk(1, 0, 1, 16'h0003, 16'h0000, 1, 1, 1, 16'h100A));
    tbl.push_back(mk(1, 0, 1, 16'h0004, 16'h0000, 1, 1, 1, 16'h0000));
    // youngest match, then drain with the head entry forwarded mid-drain
    tbl.push_back(mk(0, 1, 1, 16'h0005, 16'h1111, 1, 2, 0, 16'h0000));
    tbl.push_back(mk(0, 1, 1, 16'h0005, 16'h2222, 1, 3, 0, 16'h0000));
    tbl.push_back(mk(1, 0, 1, 16'h0005, 16'h0000, 1, 3, 1, 16'h2222));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 1, 2, 0, 16'h0000));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 1, 1, 0, 16'h0000));
    tbl.push_back(mk(1, 0, 0, 16'h0105, 16'h0000, 1, 0, 1, 16'h2222));
    tbl.push_back(mk(1, 0, 0, 16'h0003, 16'h0000, 1, 0, 1, 16'h100A));
    tbl.push_back(mk(1, 0, 0, 16'h0005, 16'h0000, 1, 0, 1, 16'h2222));
    // fill, overflow drop, drain
    tbl.push_back(mk(0, 1, 1, 16'h0010, 16'hB000, 1, 1, 0, 16'h0000));
    tbl.push_back(mk(0, 1, 1, 16'h0011, 16'hB001, 1, 2, 0, 16'h0000));
    tbl.push_back(mk(0, 1, 1, 16'h0012, 16'hB002, 1, 3, 0, 16'h0000));
    tbl.push_back(mk(0, 1, 1, 16'h0013, 16'hB003, 1, 4, 0, 16'h0000));
    tbl.push_back(mk(0, 1, 1, 16'h0014, 16'hB004, 0, 4, 0, 16'h0000));
    tbl.push_back(mk(1, 0, 1, 16'h0014, 16'h0000, 0, 4, 1, 16'h0000));
    tbl.push_back(mk(1, 0, 1, 16'h0012, 16'h0000, 0, 4, 1, 16'hB002));
    tbl.push_back(mk(0, 1, 0, 16'h0014, 16'hDEAD, 0, 3, 0, 16'h0000));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 1, 2, 0, 16'h0000));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 1, 1, 0, 16'h0000));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000));
    tbl.push_back(mk(1, 0, 0, 16'h0010, 16'h0000, 1, 0, 1, 16'hB000));
    tbl.push_back(mk(1, 0, 0, 16'h0013, 16'h0000, 1, 0, 1, 16'hB003));
    tbl.push_back(mk(1, 0, 0, 16'h0014, 16'h0000, 1, 0, 1, 16'h0000));
    // load+store together behaves as a store only
    tbl.push_back(mk(1, 1, 1, 16'h0002, 16'h1000, 1, 1, 0, 16'h0000));
    tbl.push_back(mk(1, 0, 1, 16'h0002, 16'h0000, 1, 1, 1, 16'h1000));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000));
    tbl.push_back(mk(1, 0, 0, 16'h0002, 16'h0000, 1, 0, 1, 16'h1000));

    foreach (tbl[i]) run_vec(tbl[i], $sformatf("v%0d", i));

    // ldresult must hold while no load retires
    run_vec(mk(0, 0, 0, 16'h0002, 16'h0000, 1, 0, 0, 16'h0000), "idle");
    check("hold ldresult", 32'(ldresult), 32'h1000);

    // reset with three stores pending: they must never reach memory
    run_vec(mk(0, 1, 1, 16'h0001, 16'h7777, 1, 1, 0, 16'h0000), "r0");
    run_vec(mk(0, 1, 1, 16'h0003, 16'h8888, 1, 2, 0, 16'h0000), "r1");
    run_vec(mk(0, 1, 1, 16'h0020, 16'h9999, 1, 3, 0, 16'h0000), "r2");
    run_vec(mk(1, 0, 1, 16'h0020, 16'h0000, 1, 3, 1, 16'h9999), "r3");
    rst = 1'b1; isld = 0; isst = 0; sb_hold = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst sb_count", 32'(sb_count), 0);
    check("midrst ld_valid", 32'(ld_valid), 0);
    check("midrst ldresult", 32'(ldresult), 0);
    check("midrst st_ready", 32'(st_ready), 1);
    run_vec(mk(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000), "r4");
    run_vec(mk(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000), "r5");
    run_vec(mk(1, 0, 0, 16'h0001, 16'h0000, 1, 0, 1, 16'hA5A5), "r6");
    run_vec(mk(1, 0, 0, 16'h0003, 16'h0000, 1, 0, 1, 16'h100A), "r7");
    run_vec(mk(1, 0, 0, 16'h0020, 16'h0000, 1, 0, 1, 16'h0000), "r8");

    check("scoreboard drained", 32'(sb_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
